// File: rtl/adc_capture_pkg.sv
// Shared constants and FSM encoding for the ADC capture/trigger block.
package adc_capture_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;

  localparam logic TRIG_FALLING = 1'b0;
  localparam logic TRIG_RISING  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // No reset on the array or read register so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_capture_trigger.sv
// Edge-triggered ADC capture: arm, wait for a level crossing, store DEPTH
// samples starting at the trigger sample, then allow a single sequential readout.
module adc_capture_trigger
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_sample_valid,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_trig_level,
  input  logic              i_trig_rising,
  output logic              o_armed,
  output logic              o_triggered,
  output logic              o_done,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  cap_state_e        state, state_nxt;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DATA_W-1:0] prev;
  logic              prev_vld;
  logic              rst_sync;
  logic              trig_pulse, rd_vld;
  logic              arm_ok, arm_entry, trig_hit, wr_en, rd_issue;
  logic              rise_hit, fall_hit;
  logic [DATA_W-1:0] ram_q;

  // Arm is held off for the first cycle after reset release.
  assign arm_ok = i_arm && rst_sync;

  assign rise_hit = (prev < i_trig_level) && (i_sample >= i_trig_level);
  assign fall_hit = (prev > i_trig_level) && (i_sample <= i_trig_level);
  assign trig_hit = i_sample_valid && prev_vld &&
                    ((i_trig_rising == TRIG_RISING) ? rise_hit : fall_hit);

  always_comb begin
    state_nxt = state;
    arm_entry = 1'b0;
    wr_en     = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_ok) begin
          state_nxt = ST_ARMED;
          arm_entry = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig_hit) begin
          wr_en     = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (i_sample_valid) begin
          wr_en = 1'b1;
          if (wr_addr == LAST) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Re-arm beats a coincident read and drops whatever was unread.
        if (arm_ok) begin
          state_nxt = ST_ARMED;
          arm_entry = 1'b1;
        end else if (i_rd_en) begin
          rd_issue = 1'b1;
          if (rd_addr == LAST) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      rst_sync   <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      trig_pulse <= 1'b0;
      rd_vld     <= 1'b0;
    end else begin
      state      <= state_nxt;
      rst_sync   <= 1'b1;
      trig_pulse <= (state == ST_ARMED) && trig_hit;
      rd_vld     <= rd_issue;
      if (i_sample_valid) prev <= i_sample;
      if (arm_entry)
        prev_vld <= 1'b0;
      else if (state == ST_ARMED && i_sample_valid)
        prev_vld <= 1'b1;
      // Write address wraps to 0 on the last sample, ready for the next capture.
      if (arm_entry)  wr_addr <= '0;
      else if (wr_en) wr_addr <= wr_addr + AW'(1);
      if (arm_entry)     rd_addr <= '0;
      else if (rd_issue) rd_addr <= rd_addr + AW'(1);
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (i_sample),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign o_armed     = (state == ST_ARMED);
  assign o_done      = (state == ST_DONE);
  assign o_triggered = trig_pulse;
  assign o_rd_valid  = rd_vld;
  assign o_rd_data   = rd_vld ? ram_q : '0;

endmodule
